alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that runs wide (4*NIBBLES-bit) operations through a single 4-bit ALU instance, one nibble per clock, LSB nibble first. It latches operands on a start handshake and sequences nibble selection and carry propagation. It accumulates the result and reports completion plus status flags. It sits between the register/control layer and the 4-bit ALU (opcodes ADD=0, SUB=1, AND=4, OR=5, XOR=6).

---
 rtl/alu_nibble_sequencer_if.sv | 32 +++
 rtl/alu_nibble_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle for alu_nibble_sequencer; acc_sel exists only with ALU_SEQ_ACCUM_EN.
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
`ifdef ALU_SEQ_ACCUM_EN
  logic         acc_sel;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         illegal_op;

`ifdef ALU_SEQ_ACCUM_EN
  modport master (output start, op, a, b, carry_in, acc_sel,
                  input  busy, done, result, carry_out, overflow, zero, illegal_op);
  modport slave  (input  start, op, a, b, carry_in, acc_sel,
                  output busy, done, result, carry_out, overflow, zero, illegal_op);
`else
  modport master (output start, op, a, b, carry_in,
                  input  busy, done, result, carry_out, overflow, zero, illegal_op);
  modport slave  (input  start, op, a, b, carry_in,
                  output busy, done, result, carry_out, overflow, zero, illegal_op);
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs 4*NIBBLES-bit ADD/SUB/AND/OR/XOR through one 4-bit ALU, LSB nibble first.
// Optional macro ALU_SEQ_ACCUM_EN: acc_sel=1 at start takes operand A from the result register.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_nibble_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd4,
                         OP_OR  = 3'd5, OP_XOR = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_a, r_beff, r_result, w_res_next, w_a_src;
  logic [2:0]    r_aluop;
  logic          r_arith, r_carry;
  logic [KW-1:0] r_k;
  logic          r_cout, r_ovf, r_zero, r_ill;
  logic          w_legal, w_accept, w_last, w_busy, w_done;
  logic [3:0]    w_alu_a, w_alu_b, w_alu_y;
  logic          w_alu_cin, w_alu_cout;

  assign w_legal  = (bus.op == OP_ADD) || (bus.op == OP_SUB) || (bus.op == OP_AND) ||
                    (bus.op == OP_OR)  || (bus.op == OP_XOR);
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_k == KW'(NIBBLES - 1));

`ifdef ALU_SEQ_ACCUM_EN
  assign w_a_src = bus.acc_sel ? r_result : bus.a;
`else
  assign w_a_src = bus.a;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_legal ? S_RUN : S_DONE;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // 4-bit ALU slice; SUB arrives here already folded into ADD with inverted B and carry.
  assign w_alu_a   = r_a[4*r_k +: 4];
  assign w_alu_b   = r_beff[4*r_k +: 4];
  assign w_alu_cin = r_arith ? r_carry : 1'b0;

  always_comb begin
    w_alu_y    = 4'd0;
    w_alu_cout = 1'b0;
    case (r_aluop)
      OP_ADD:  {w_alu_cout, w_alu_y} = {1'b0, w_alu_a} + {1'b0, w_alu_b} + {4'd0, w_alu_cin};
      OP_AND:  w_alu_y = w_alu_a & w_alu_b;
      OP_OR:   w_alu_y = w_alu_a | w_alu_b;
      OP_XOR:  w_alu_y = w_alu_a ^ w_alu_b;
      default: ;
    endcase
  end

  always_comb begin
    w_res_next              = r_result;
    w_res_next[4*r_k +: 4]  = w_alu_y;
  end

  // Flags are loaded on the last RUN edge so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_beff   <= '0;
      r_result <= '0;
      r_aluop  <= OP_ADD;
      r_arith  <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_accept) begin
      if (w_legal) begin
        r_a      <= w_a_src;
        r_beff   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
        r_aluop  <= (bus.op == OP_SUB) ? OP_ADD : bus.op;
        r_arith  <= (bus.op == OP_ADD) || (bus.op == OP_SUB);
        r_carry  <= (bus.op == OP_SUB) ? ~bus.carry_in : bus.carry_in;
        r_k      <= '0;
        r_result <= '0;
        r_cout   <= 1'b0;
        r_ovf    <= 1'b0;
        r_zero   <= 1'b0;
        r_ill    <= 1'b0;
      end else begin
        r_ill    <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_result <= w_res_next;
      r_carry  <= w_alu_cout;
      r_k      <= r_k + KW'(1);
      if (w_last) begin
        r_cout <= r_arith & w_alu_cout;
        r_ovf  <= r_arith && (r_a[W-1] == r_beff[W-1]) && (w_res_next[W-1] != r_a[W-1]);
        r_zero <= (w_res_next == '0);
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.result     = r_result;
  assign bus.carry_out  = r_cout;
  assign bus.overflow   = r_ovf;
  assign bus.zero       = r_zero;
  assign bus.illegal_op = r_ill;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench: stimulus pushes reference-model results, a negedge monitor pops on done.
module tb_alu_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_nibble_sequencer_if #(.NIBBLES(N)) bus();
  alu_nibble_sequencer #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic         cout, ovf, zero, ill;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           n_chk = 0, n_fail = 0, cyc = 0;
  logic [W-1:0] m_res = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic on integers, signed overflow as a range test.
  task automatic model_push(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin, logic acc);
    exp_t e;
    logic [W-1:0] ea;
    longint s, ss, sa, sb, ci, lim;
    ea  = acc ? m_res : a;
    ci  = longint'(cin);
    sa  = $signed(ea);
    sb  = $signed(b);
    lim = longint'(1) << (W - 1);
    e.ill = 1'b0; e.ovf = 1'b0; e.cout = 1'b0; e.res = '0;
    case (op)
      3'd0: begin
        s = longint'(ea) + longint'(b) + ci;
        e.res = s[W-1:0]; e.cout = ((s >> W) != 0);
        ss = sa + sb + ci; e.ovf = (ss >= lim) || (ss < -lim);
      end
      3'd1: begin
        s = longint'(ea) - longint'(b) - ci;
        e.res = s[W-1:0]; e.cout = (s >= 0);
        ss = sa - sb - ci; e.ovf = (ss >= lim) || (ss < -lim);
      end
      3'd4: e.res = ea & b;
      3'd5: e.res = ea | b;
      3'd6: e.res = ea ^ b;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.res = m_res; e.cout = m_cout; e.ovf = m_ovf; e.zero = m_zero;
    end else begin
      e.zero = (e.res == '0);
      m_res = e.res; m_cout = e.cout; m_ovf = e.ovf; m_zero = e.zero;
    end
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("idle_timeout", 64'(t), 64'd0);
  endtask

  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin, logic acc, bit push);
    wait_idle();
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.carry_in = cin;
`ifdef ALU_SEQ_ACCUM_EN
    bus.acc_sel = acc;
`endif
    if (push) model_push(op, a, b, cin, acc);
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.carry_in = 1'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    int   bc;
    bc = 0;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("result",     64'(bus.result),     64'(e.res));
          chk("carry_out",  64'(bus.carry_out),  64'(e.cout));
          chk("overflow",   64'(bus.overflow),   64'(e.ovf));
          chk("zero",       64'(bus.zero),       64'(e.zero));
          chk("illegal_op", 64'(bus.illegal_op), 64'(e.ill));
          chk("latency",    64'(cyc - e.acc),    e.ill ? 64'd1 : 64'(N + 1));
          chk("busy_cycles", 64'(bc),            e.ill ? 64'd0 : 64'(N));
        end
        bc = 0;
      end else if (bus.busy) bc++;
      else bc = 0;
    end
  end

  initial begin : stim
    logic [2:0] optab [10];
    logic [W-1:0] edge_v [4];
    logic [W-1:0] ra, rb;
    logic racc;
    int t;
    optab  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    edge_v = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
    bus.acc_sel = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", {60'd0, bus.carry_out, bus.overflow, bus.zero, bus.illegal_op}, 64'd0);
    rst = 1'b0;

    issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    issue(3'd1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1);
    issue(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1);
    issue(3'd6, 16'hF0F0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(3'd4, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    issue(3'd5, 16'h1200, 16'h0034, 1'b0, 1'b0, 1'b1);
    issue(3'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(3'd3, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b1);

    // start pulses during RUN and during DONE must be ignored
    issue(3'd0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 16'h9999; bus.b = 16'h0123;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (!bus.done && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("done_timeout", 64'(t), 64'd0);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h4444;
    @(negedge clk);
    bus.start = 1'b0;

    // reset in the second RUN cycle aborts with no done pulse
    issue(3'd0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    m_res = '0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    repeat (10) @(negedge clk);

`ifdef ALU_SEQ_ACCUM_EN
    issue(3'd0, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1);
    issue(3'd0, 16'hDEAD, 16'h0002, 1'b0, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      racc = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
      racc = 1'($urandom);
`endif
      issue(optab[$urandom_range(0, 9)], ra, rb, 1'($urandom), racc, 1'b1);
    end

    t = 0;
    while (q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
